// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO mult/div scheduler: op bit positions,
// FSM encoding, divide iteration count and sign helpers.
package muldiv_pkg;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MFHI  = 4;
  localparam int OP_MFLO  = 5;
  localparam int OP_MTHI  = 6;
  localparam int OP_MTLO  = 7;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL      = 2'd1,
    DIV      = 2'd2,
    DONE_DIV = 2'd3
  } state_t;

  function automatic logic op_onehot(input logic [7:0] op);
    return (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Restores the sign of a magnitude result; two's complement negate when neg.
  function automatic logic [31:0] sign_fix(input logic [31:0] mag, input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// Command channel between EXE and the mult/div scheduler, including the
// combinational MFHI/MFLO read-back.
interface muldiv_sched_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [7:0]      req_op;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            req_ready;
  logic [XLEN-1:0] mf_data;

  modport master (
    output req_valid, req_op, req_src1, req_src2,
    input  req_ready, mf_data
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2,
    output req_ready, mf_data
  );
endinterface

// File: rtl/div_iter.sv
// One restoring-division step: shift in the next dividend bit, trial subtract,
// keep the difference when it does not go negative.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // The partial remainder is always below the divisor, so trial fits XLEN+1
  // bits and the top bit of diff is a clean borrow flag.
  assign trial   = {rem, quo[XLEN-1]};
  assign diff    = trial - {1'b0, divisor};
  assign q_bit   = ~diff[XLEN];
  assign rem_nxt = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
endmodule

// File: rtl/muldiv_sched.sv
// HI/LO owner: multi-cycle multiply, 32-step restoring divide, MF/MT access.
// Define MULDIV_EARLY_DIV_EN to short-cut divides where |divisor| > |dividend|.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  muldiv_sched_if.slave   bus,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  state_t state, state_nxt;
  logic [2:0] mul_cnt;
  logic [5:0] div_cnt;
  logic [XLEN-1:0] hi, lo;

  logic [XLEN-1:0] mul_a, mul_b;
  logic            mul_signed;
  logic signed [2*XLEN-1:0] mul_a_ext, mul_b_ext, product;

  logic [XLEN-1:0] rem, quo, dvs, rem_nxt;
  logic            q_bit, quo_neg, rem_neg, div_bypass;

  logic            accept, is_mul, is_div, div_signed, div_zero, div_short;
  logic [XLEN-1:0] mag1, mag2;

  assign bus.req_ready = (state == IDLE) && !flush;
  assign bus.mf_data   = bus.req_op[OP_MFHI] ? hi : lo;
  assign hi_out        = hi;
  assign lo_out        = lo;

  assign accept     = bus.req_valid && bus.req_ready && op_onehot(bus.req_op);
  assign is_mul     = accept && (bus.req_op[OP_MULT] || bus.req_op[OP_MULTU]);
  assign is_div     = accept && (bus.req_op[OP_DIV]  || bus.req_op[OP_DIVU]);
  assign div_signed = bus.req_op[OP_DIV];
  assign div_zero   = (bus.req_src2 == '0);
  assign mag1       = magnitude(bus.req_src1, div_signed);
  assign mag2       = magnitude(bus.req_src2, div_signed);

`ifdef MULDIV_EARLY_DIV_EN
  assign div_short = (mag2 > mag1);
`else
  assign div_short = 1'b0;
`endif

  assign mul_a_ext = mul_signed ? {{XLEN{mul_a[XLEN-1]}}, mul_a} : {{XLEN{1'b0}}, mul_a};
  assign mul_b_ext = mul_signed ? {{XLEN{mul_b[XLEN-1]}}, mul_b} : {{XLEN{1'b0}}, mul_b};
  assign product   = mul_a_ext * mul_b_ext;

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (is_mul)      state_nxt = MUL;
        else if (is_div) state_nxt = (div_zero || div_short) ? DONE_DIV : DIV;
      end
      MUL: begin
        if (mul_cnt == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIV: begin
        if (div_cnt == '0) state_nxt = DONE_DIV;
      end
      DONE_DIV: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A flush abandons the operation, including a commit landing this cycle.
    if (flush && state != IDLE) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mul_cnt <= '0;
      div_cnt <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nxt;

      if (is_mul)                          mul_cnt <= 3'(MUL_LAT - 1);
      else if (state == MUL && mul_cnt != '0) mul_cnt <= mul_cnt - 3'd1;

      if (is_div)                          div_cnt <= 6'(DIV_ITERS - 1);
      else if (state == DIV && div_cnt != '0) div_cnt <= div_cnt - 6'd1;

      if (done && state == MUL) begin
        {hi, lo} <= product;
      end else if (done && state == DONE_DIV) begin
        hi <= div_bypass ? rem : sign_fix(rem, rem_neg);
        lo <= div_bypass ? quo : sign_fix(quo, quo_neg);
      end else if (accept) begin
        if (bus.req_op[OP_MTHI]) hi <= bus.req_src1;
        if (bus.req_op[OP_MTLO]) lo <= bus.req_src1;
      end
    end
  end

  // Operand and iteration datapath; its contents only matter while busy.
  always_ff @(posedge clk) begin
    if (is_mul) begin
      mul_a      <= bus.req_src1;
      mul_b      <= bus.req_src2;
      mul_signed <= bus.req_op[OP_MULT];
    end
    if (is_div) begin
      dvs        <= mag2;
      div_bypass <= div_zero || div_short;
      quo_neg    <= div_signed && (bus.req_src1[XLEN-1] ^ bus.req_src2[XLEN-1]);
      rem_neg    <= div_signed && bus.req_src1[XLEN-1];
      if (div_zero) begin
        quo <= '1;
        rem <= bus.req_src1;
      end else if (div_short) begin
        quo <= '0;
        rem <= bus.req_src1;
      end else begin
        quo <= mag1;
        rem <= '0;
      end
    end else if (state == DIV) begin
      rem <= rem_nxt;
      quo <= {quo[XLEN-2:0], q_bit};
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: directed cases plus random commands against an
// arithmetic HI/LO model with per-cycle busy/done/ready expectations.
module tb_muldiv_sched;

  localparam int MUL_LAT = 2;
  localparam logic [7:0] C_MULT  = 8'h01;
  localparam logic [7:0] C_MULTU = 8'h02;
  localparam logic [7:0] C_DIV   = 8'h04;
  localparam logic [7:0] C_DIVU  = 8'h08;
  localparam logic [7:0] C_MFHI  = 8'h10;
  localparam logic [7:0] C_MFLO  = 8'h20;
  localparam logic [7:0] C_MTHI  = 8'h40;
  localparam logic [7:0] C_MTLO  = 8'h80;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_sched_if #(.XLEN(32)) bus ();

  muldiv_sched #(.MUL_LAT(MUL_LAT), .XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.req_op    = 8'h00;
    bus.req_src1  = 32'd0;
    bus.req_src2  = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic b, input logic d, input logic r);
    check({tag, ".busy"},  busy,          b);
    check({tag, ".done"},  done,          d);
    check({tag, ".ready"}, bus.req_ready, r);
  endtask

  // Architectural result of a command: HI/LO afterwards and cycles to done.
  function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint x, y, p, q, r;
    logic [63:0] pv;
    hi  = m_hi;
    lo  = m_lo;
    lat = 0;
    if (op == C_MULT || op == C_MULTU) begin
      x  = (op == C_MULT) ? longint'($signed(a)) : longint'({32'd0, a});
      y  = (op == C_MULT) ? longint'($signed(b)) : longint'({32'd0, b});
      p  = x * y;
      pv = p;
      hi = pv[63:32];
      lo = pv[31:0];
      lat = MUL_LAT;
    end else if (op == C_DIV || op == C_DIVU) begin
      if (b == 32'd0) begin
        hi  = a;
        lo  = 32'hFFFF_FFFF;
        lat = 1;
      end else begin
        x  = (op == C_DIV) ? longint'($signed(a)) : longint'({32'd0, a});
        y  = (op == C_DIV) ? longint'($signed(b)) : longint'({32'd0, b});
        q  = x / y;
        r  = x % y;
        pv = q;
        lo = pv[31:0];
        pv = r;
        hi = pv[31:0];
        lat = 33;
`ifdef MULDIV_EARLY_DIV_EN
        if (((y < 0) ? -y : y) > ((x < 0) ? -x : x)) lat = 1;
`endif
      end
    end
  endfunction

  // Issues one command in the current cycle and follows it to completion.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] e_hi, e_lo;
    int lat;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    #1;
    check({tag, ".accept"}, bus.req_ready, 1'b1);
    if (op == C_MFHI) check({tag, ".mf_data"}, bus.mf_data, m_hi);
    if (op == C_MFLO) check({tag, ".mf_data"}, bus.mf_data, m_lo);
    model(op, a, b, e_hi, e_lo, lat);
    next_cycle();
    idle_bus();
    if (op == C_MTHI) m_hi = a;
    if (op == C_MTLO) m_lo = a;
    for (int c = 1; c <= lat; c++) begin
      #1;
      check_ctrl($sformatf("%s.c%0d", tag, c), 1'b1, (c == lat), 1'b0);
      next_cycle();
    end
    if (lat > 0) begin
      m_hi = e_hi;
      m_lo = e_lo;
    end
    #1;
    check_ctrl({tag, ".after"}, 1'b0, 1'b0, 1'b1);
    check({tag, ".hi"}, hi_out, m_hi);
    check({tag, ".lo"}, lo_out, m_lo);
  endtask

  task automatic bad_op(input logic [7:0] op, input string tag);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = 32'hA5A5_0F0F;
    bus.req_src2  = 32'h0000_0003;
    #1;
    check({tag, ".ready"}, bus.req_ready, 1'b1);
    next_cycle();
    idle_bus();
    #1;
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".hi"}, hi_out, m_hi);
    check({tag, ".lo"}, lo_out, m_lo);
  endtask

  initial begin
    logic [7:0]  ops [8];
    logic [7:0]  op;
    logic [31:0] a, b;
    ops = '{C_MULT, C_MULTU, C_DIV, C_DIVU, C_MFHI, C_MFLO, C_MTHI, C_MTLO};

    idle_bus();
    #12;
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.hi", hi_out, 32'd0);
    check("reset.lo", lo_out, 32'd0);
    check("reset.mf_data", bus.mf_data, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    #1;

    run_op(C_MTHI,  32'h1234_5678, 32'd0, "mthi");
    run_op(C_MFHI,  32'd0, 32'd0, "mfhi");
    run_op(C_MULT,  32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    run_op(C_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
    run_op(C_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
    run_op(C_DIVU,  32'd100, 32'd0, "divu_by0");
    run_op(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(C_DIVU,  32'd5, 32'd9, "divu_5_9");
    run_op(C_DIV,   32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_op(C_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, "div_m7_m2");
    run_op(C_MTLO,  32'h0000_0055, 32'd0, "mtlo");
    run_op(C_MFLO,  32'd0, 32'd0, "mflo");

    bad_op(8'h00, "op_none");
    bad_op(8'h03, "op_two");
    bad_op(8'hC0, "op_mt_both");

    // Flush during a divide; a command in the flush cycle is refused.
    bus.req_valid = 1'b1;
    bus.req_op    = C_DIVU;
    bus.req_src1  = 32'd1000;
    bus.req_src2  = 32'd7;
    #1;
    check("fl_div.accept", bus.req_ready, 1'b1);
    next_cycle();
    idle_bus();
    repeat (9) next_cycle();
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = C_MTHI;
    bus.req_src1  = 32'h0000_DEAD;
    #1;
    check_ctrl("fl_div.t10", 1'b1, 1'b0, 1'b0);
    next_cycle();
    flush = 1'b0;
    bus.req_op   = C_MTLO;
    bus.req_src1 = 32'h0000_BEEF;
    #1;
    check_ctrl("fl_div.t11", 1'b0, 1'b0, 1'b1);
    check("fl_div.hi", hi_out, m_hi);
    check("fl_div.lo", lo_out, m_lo);
    next_cycle();
    idle_bus();
    m_lo = 32'h0000_BEEF;
    #1;
    check("fl_div.mt_hi", hi_out, m_hi);
    check("fl_div.mt_lo", lo_out, m_lo);

    // Flush landing on the multiply commit cycle.
    bus.req_valid = 1'b1;
    bus.req_op    = C_MULT;
    bus.req_src1  = 32'd7;
    bus.req_src2  = 32'd9;
    #1;
    check("fl_mul.accept", bus.req_ready, 1'b1);
    next_cycle();
    idle_bus();
    for (int c = 1; c < MUL_LAT; c++) next_cycle();
    flush = 1'b1;
    #1;
    check("fl_mul.busy", busy, 1'b1);
    check("fl_mul.done", done, 1'b0);
    next_cycle();
    flush = 1'b0;
    #1;
    check("fl_mul.idle", busy, 1'b0);
    check("fl_mul.hi", hi_out, m_hi);
    check("fl_mul.lo", lo_out, m_lo);

    // Reset asserted in the middle of a divide.
    run_op(C_MTHI, 32'h0BAD_F00D, 32'd0, "pre_rst");
    bus.req_valid = 1'b1;
    bus.req_op    = C_DIV;
    bus.req_src1  = 32'd12345;
    bus.req_src2  = 32'd11;
    #1;
    next_cycle();
    idle_bus();
    repeat (4) next_cycle();
    rst_n = 1'b0;
    #1;
    check("rst_mid.busy", busy, 1'b0);
    check("rst_mid.done", done, 1'b0);
    check("rst_mid.hi", hi_out, 32'd0);
    check("rst_mid.lo", lo_out, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    next_cycle();
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 2))
        0:       a = $urandom_range(0, 40);
        1:       a = 32'h0 - $urandom_range(1, 40);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'h0 - $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(op, a, b, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Scheduler and owner of the HI/LO register pair for the integer pipeline.
- Accepts one mult_div_op command per handshake from EXE (the 8-bit op produced by decode) with rs/rt operands.
- Sequences a multi-cycle multiplier or an iterative radix-2 divider, commits results to HI/LO, and serves MFHI/MFLO/MTHI/MTLO.
- Provides the busy interlock EXE uses to stall, and cancels in-flight work on the WB exception/ERET flush (wb_ClrStpJmp).

Parameters:
- MUL_LAT, 2, cycles from multiply accept to commit; legal range 1..4.
- XLEN, 32, operand/HI/LO width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  EXE presents a command
- req_op  in  8  one-hot: [0]MULT [1]MULTU [2]DIV [3]DIVU [4]MFHI [5]MFLO [6]MTHI [7]MTLO
- req_src1  in  32  rs value (dividend / multiplicand / MT source)
- req_src2  in  32  rt value (divisor / multiplier)
- flush  in  1  wb_ClrStpJmp; cancels everything in flight
- req_ready  out  1  command accepted when req_valid && req_ready
- busy  out  1  multiply or divide in progress
- done  out  1  one-cycle pulse in the cycle HI/LO are written by a mult/div
- mf_data  out  32  HI (MFHI) or LO (MFLO) for the accepted MF command, combinational
- hi_out  out  32  current HI
- lo_out  out  32  current LO

Behaviour:
- Reset values (async): state IDLE, HI=LO=0, busy=0, done=0, counters 0. mf_data follows the HI/LO mux and reads 0 after reset.
- req_ready = (state==IDLE) && !flush. A req_op of all zeros or more than one bit set is ignored with no state change.
- FSM states:
  - IDLE: MFHI/MFLO: mf_data valid in the accept cycle, no state change. MTHI/MTLO: HI or LO <= src1 at the end of the accept cycle. MULT/MULTU -> MUL. DIV/DIVU -> DIV (or DONE_DIV when the divisor is 0).
  - MUL: counter runs from MUL_LAT-1 down. At 0: done=1, {HI,LO} <= 64-bit product (signed for MULT, unsigned for MULTU), -> IDLE.
  - DIV: operands latched as magnitudes with the sign of each recorded. 32 restoring iterations, one per cycle (cycles T+1..T+32 after accept cycle T), then -> DONE_DIV.
  - DONE_DIV (T+33): sign fix-up; quotient sign = s1^s2, remainder sign = sign of the dividend; LO <= quotient, HI <= remainder; done=1; -> IDLE.
- Divide by zero: go directly to DONE_DIV the cycle after accept; LO=0xFFFFFFFF, HI=src1. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- busy=1 in MUL, DIV and DONE_DIV. busy=0 in IDLE.
- Back-to-back: a new command can be accepted in the cycle after done.
- Flush:
  - In any non-IDLE state: state -> IDLE at the next edge; HI/LO are not written; done is suppressed even if it coincides with the commit cycle.
  - In the same cycle as a req_valid: the command is not accepted.
  - In IDLE: no effect.
- MTHI/MTLO and commits never coincide, because req_ready is low while busy.
- Reset asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MULDIV_EARLY_DIV_EN.
- Defined: in the accept cycle of DIV/DIVU, if |src2| > |src1| (unsigned compare of magnitudes), skip the iterations. DONE_DIV follows in the next cycle with LO=0 and HI=src1 (original signed value). Total latency 2 cycles instead of 34.
- Undefined: every non-zero-divisor divide takes the full 32 iterations.
- Divide-by-zero handling is identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op bit index localparams (OP_MULT..OP_MTLO)
  - FSM state encoding (IDLE, MUL, DIV, DONE_DIV)
  - DIV_ITERS=32
  - the helper function for the sign fix-up
- Sub-module div_iter: one combinational restoring step. It takes the partial remainder, the quotient shift register and the divisor magnitude, and returns the next remainder and quotient bit. Instantiated once and registered by muldiv_sched.

Test Plan:
- MTHI 0x12345678, then MFHI in the next cycle -> mf_data=0x12345678 in the accept cycle; lo_out unchanged at 0.
- MULT 0xFFFFFFFE x 0x00000003 with MUL_LAT=2 -> done at T+2, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> busy T+1..T+33, done at T+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF. req_ready=0 throughout busy.
- DIVU 100 / 0 -> done at T+1, LO=0xFFFFFFFF, HI=100.
- DIV in flight, flush pulsed at T+10 -> IDLE at T+11, no done, HI/LO keep their pre-divide values. A command offered at T+10 is not accepted; one offered at T+11 is accepted.
- With MULDIV_EARLY_DIV_EN: DIVU 5 / 9 -> done at T+1, LO=0, HI=5. Without the macro: done at T+33 with the same result.
